// File: rtl/decompress_stream.sv
// Streams packed d-bit coefficients through a bit gearbox, applies Decompress_d and writes COEFF_PER_CLK per beat; DECOMPRESS_STREAM_RANGE_CHK_EN adds the d=12 range flag.
// Latency: first write three cycles after the first read. Backpressure: mem_wr_ready low holds the write beat and stalls pops.
module decompress_stream #(
    parameter int COEFF_PER_CLK = 4,
    parameter int RD_W          = 64,
    parameter int BUF_W         = 128,
    parameter int ADDR_W        = 15,
    parameter int OUT_W         = 24,
    parameter int N             = 256,
    parameter int Q             = 3329
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           zeroize,
    input  logic                           decompress_enable,
    input  logic [3:0]                     d_sel,
    input  logic [2:0]                     num_poly,
    input  logic [ADDR_W-1:0]              src_base_addr,
    input  logic [ADDR_W-1:0]              dest_base_addr,
    output logic                           api_rd_en,
    output logic [ADDR_W-1:0]              api_rd_addr,
    input  logic [RD_W-1:0]                api_rd_data,
    output logic                           mem_wr_en,
    output logic [ADDR_W-1:0]              mem_wr_addr,
    output logic [COEFF_PER_CLK*OUT_W-1:0] mem_wr_data,
    input  logic                           mem_wr_ready,
    output logic                           busy,
    output logic                           decompress_done,
    output logic                           err_illegal_d,
    output logic                           err_range
);
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [3:0]                     d_r;
    logic [ADDR_W-1:0]              rd_addr, wr_addr;
    logic [CNT_W-1:0]               rd_cnt, wr_cnt, total_rd, total_wr;
    logic [BUF_W-1:0]               gbuf, push_word, merged, gbuf_nxt;
    logic [FILL_W-1:0]              fill, fill_nxt, pop_bits;
    logic [FILL_W:0]                pending_fill;
    logic                           inflight, out_vld, illegal_q;
    logic [COEFF_PER_CLK*OUT_W-1:0] out_dat, coef_dat;
    logic [11:0]                    d_mask, x;
    logic                           d_legal, start, start_run, start_zero, start_bad;
    logic                           rd_issue, pop, wr_acc, last_wr;

    function automatic logic [11:0] decomp(input logic [11:0] xin, input logic [3:0] d);
        logic [23:0] p;
        p = 24'(xin) * 24'(Q) + (24'd1 << (d - 4'd1));
        if (d == 4'd12) return xin;
        return 12'(p >> d);
    endfunction

    assign d_legal    = (d_sel != 4'd0) && (d_sel <= 4'd12);
    assign start      = (state == IDLE) && decompress_enable;
    assign start_run  = start && d_legal && (num_poly != 3'd0);
    assign start_zero = start && d_legal && (num_poly == 3'd0);
    assign start_bad  = start && !d_legal;

    assign pop_bits     = FILL_W'(COEFF_PER_CLK * int'(d_r));
    assign d_mask       = 12'((13'd1 << d_r) - 13'd1);
    // Room check counts the word still in flight so a push can never overflow the buffer.
    assign pending_fill = {1'b0, fill} + (inflight ? (FILL_W+1)'(RD_W) : '0);
    assign rd_issue     = (state == RUN) && (rd_cnt < total_rd) &&
                          (pending_fill <= (FILL_W+1)'(BUF_W - RD_W));
    assign wr_acc       = out_vld && mem_wr_ready;
    assign pop          = (state == RUN) && (fill >= pop_bits) && (!out_vld || mem_wr_ready);
    assign last_wr      = wr_acc && (wr_cnt == total_wr - CNT_W'(1));

    assign push_word = {{(BUF_W-RD_W){1'b0}}, api_rd_data} << fill;
    assign merged    = inflight ? (gbuf | push_word) : gbuf;
    assign gbuf_nxt  = pop ? (merged >> pop_bits) : merged;
    assign fill_nxt  = fill + (inflight ? FILL_W'(RD_W) : '0) - (pop ? pop_bits : '0);

`ifdef DECOMPRESS_STREAM_RANGE_CHK_EN
    logic range_hit;
    logic err_r;
`endif

    always_comb begin
        coef_dat = '0;
        x        = '0;
`ifdef DECOMPRESS_STREAM_RANGE_CHK_EN
        range_hit = 1'b0;
`endif
        for (int i = 0; i < COEFF_PER_CLK; i++) begin
            x = 12'(gbuf >> (i * int'(d_r))) & d_mask;
            coef_dat[i*OUT_W +: OUT_W] = OUT_W'(decomp(x, d_r));
`ifdef DECOMPRESS_STREAM_RANGE_CHK_EN
            if ((d_r == 4'd12) && (x >= 12'(Q))) range_hit = 1'b1;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_run) state_nxt = RUN;
                     else if (start_zero) state_nxt = DONE;
            RUN:     if (last_wr) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || zeroize) state <= IDLE;
        else                  state <= state_nxt;
    end

    // Zeroize clears the buffer as well as the control state so no key bits survive an abort.
    always_ff @(posedge clk) begin
        if (reset || zeroize) begin
            d_r <= '0; rd_addr <= '0; wr_addr <= '0;
            rd_cnt <= '0; wr_cnt <= '0; total_rd <= '0; total_wr <= '0;
            gbuf <= '0; fill <= '0; inflight <= 1'b0;
            out_vld <= 1'b0; out_dat <= '0; illegal_q <= 1'b0;
        end else begin
            illegal_q <= start_bad;
            if (start_run) begin
                d_r      <= d_sel;
                rd_addr  <= src_base_addr;
                wr_addr  <= dest_base_addr;
                rd_cnt   <= '0;
                wr_cnt   <= '0;
                total_rd <= (CNT_W'(num_poly) * CNT_W'(N) * CNT_W'(d_sel)) / CNT_W'(RD_W);
                total_wr <= (CNT_W'(num_poly) * CNT_W'(N)) / CNT_W'(COEFF_PER_CLK);
            end
            if (rd_issue) begin
                rd_addr <= rd_addr + ADDR_W'(1);
                rd_cnt  <= rd_cnt + CNT_W'(1);
            end
            inflight <= rd_issue;
            gbuf     <= gbuf_nxt;
            fill     <= fill_nxt;
            if (pop) begin
                out_vld <= 1'b1;
                out_dat <= coef_dat;
            end else if (wr_acc) begin
                out_vld <= 1'b0;
            end
            if (wr_acc) begin
                wr_addr <= wr_addr + ADDR_W'(1);
                wr_cnt  <= wr_cnt + CNT_W'(1);
            end
        end
    end

`ifdef DECOMPRESS_STREAM_RANGE_CHK_EN
    always_ff @(posedge clk) begin
        if (reset || zeroize)           err_r <= 1'b0;
        else if (start_run || start_zero) err_r <= 1'b0;
        else if (pop && range_hit)      err_r <= 1'b1;
    end
    assign err_range = err_r;
`else
    assign err_range = 1'b0;
`endif

    assign api_rd_en       = rd_issue;
    assign api_rd_addr     = rd_addr;
    assign mem_wr_en       = out_vld;
    assign mem_wr_addr     = wr_addr;
    assign mem_wr_data     = out_dat;
    assign busy            = (state != IDLE);
    assign decompress_done = (state == DONE);
    assign err_illegal_d   = illegal_q;
endmodule

// File: tb/tb_decompress_stream.sv
// Directed bench for decompress_stream: API responder, write capture and a bit-serial reference model.
module tb_decompress_stream;
    logic        clk = 1'b0;
    logic        reset, zeroize, decompress_enable;
    logic [3:0]  d_sel;
    logic [2:0]  num_poly;
    logic [14:0] src_base_addr, dest_base_addr;
    logic        api_rd_en;
    logic [14:0] api_rd_addr;
    logic [63:0] api_rd_data;
    logic        mem_wr_en;
    logic [14:0] mem_wr_addr;
    logic [95:0] mem_wr_data;
    logic        mem_wr_ready;
    logic        busy, decompress_done, err_illegal_d, err_range;

    always #5 clk = ~clk;

    decompress_stream #(.COEFF_PER_CLK(4), .RD_W(64), .BUF_W(128), .ADDR_W(15),
                        .OUT_W(24), .N(256), .Q(3329)) dut (
        .clk(clk), .reset(reset), .zeroize(zeroize), .decompress_enable(decompress_enable),
        .d_sel(d_sel), .num_poly(num_poly), .src_base_addr(src_base_addr),
        .dest_base_addr(dest_base_addr), .api_rd_en(api_rd_en), .api_rd_addr(api_rd_addr),
        .api_rd_data(api_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_ready(mem_wr_ready), .busy(busy),
        .decompress_done(decompress_done), .err_illegal_d(err_illegal_d), .err_range(err_range)
    );

    int n_assert = 0, n_fail = 0;
    int cyc = 0, c0 = 0;
    int n_wr, n_rd, rd_seq_err, hold_err, done_cnt, done_cyc, ill_cnt, cur_src, ready_mode;
    logic [63:0] api_mem [0:511];
    logic [14:0] wr_addr_log [0:511];
    logic [95:0] wr_data_log [0:511];
    logic        rd_pend, hold_prev;
    logic [14:0] rd_pend_addr, hold_addr;
    logic [95:0] hold_data;
    logic        exp_rng;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        mem_wr_ready = (ready_mode == 1) ? ~mem_wr_ready : 1'b1;
        api_rd_data  = rd_pend ? api_mem[rd_pend_addr[8:0]] : 64'h0;
        if (hold_prev && !(mem_wr_en && mem_wr_addr == hold_addr && mem_wr_data == hold_data))
            hold_err++;
        hold_prev = mem_wr_en && !mem_wr_ready;
        hold_addr = mem_wr_addr;
        hold_data = mem_wr_data;
        if (mem_wr_en && mem_wr_ready && n_wr < 512) begin
            wr_addr_log[n_wr] = mem_wr_addr;
            wr_data_log[n_wr] = mem_wr_data;
            n_wr++;
        end
        if (api_rd_en) begin
            if (api_rd_addr != 15'(cur_src + n_rd)) rd_seq_err++;
            n_rd++;
        end
        rd_pend      = api_rd_en;
        rd_pend_addr = api_rd_addr;
        if (decompress_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err_illegal_d) ill_cnt++;
    endtask

    task automatic start_op(input int d, input int np, input int src, input int dst);
        n_wr = 0; n_rd = 0; rd_seq_err = 0; hold_err = 0; done_cnt = 0; ill_cnt = 0;
        hold_prev = 1'b0;
        cur_src = src;
        d_sel = 4'(d); num_poly = 3'(np);
        src_base_addr = 15'(src); dest_base_addr = 15'(dst);
        decompress_enable = 1'b1;
        c0 = cyc;
        tick();
        decompress_enable = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        while (done_cnt == 0 && (cyc - c0) < max_cyc) tick();
        repeat (2) tick();
    endtask

    // Reference: pull each coefficient bit by bit out of the LSB-first word stream.
    function automatic int verify(input int d, input int np, input int src, input int dst);
        int errs, x, y, p;
        logic [95:0] exp;
        errs = 0;
        if (n_wr != np * 64) errs++;
        for (int w = 0; w < n_wr && w < np * 64; w++) begin
            exp = '0;
            for (int i = 0; i < 4; i++) begin
                x = 0;
                for (int b = 0; b < d; b++) begin
                    p = (w * 4 + i) * d + b;
                    if (api_mem[(src + p / 64) % 512][p % 64]) x = x | (1 << b);
                end
                y = (d == 12) ? x : ((x * 3329 + (1 << (d - 1))) >> d);
                exp[i*24 +: 24] = 24'(y);
            end
            if (wr_data_log[w] !== exp || wr_addr_log[w] !== 15'(dst + w)) errs++;
        end
        return errs;
    endfunction

    initial begin
`ifdef DECOMPRESS_STREAM_RANGE_CHK_EN
        exp_rng = 1'b1;
`else
        exp_rng = 1'b0;
`endif
        reset = 1'b1; zeroize = 1'b0; decompress_enable = 1'b0;
        d_sel = '0; num_poly = '0; src_base_addr = '0; dest_base_addr = '0;
        mem_wr_ready = 1'b1; api_rd_data = '0; ready_mode = 0;
        rd_pend = 1'b0; hold_prev = 1'b0; rd_pend_addr = '0; hold_addr = '0; hold_data = '0;
        n_wr = 0; n_rd = 0; rd_seq_err = 0; hold_err = 0; done_cnt = 0; done_cyc = 0;
        ill_cnt = 0; cur_src = 0;
        for (int i = 0; i < 512; i++) api_mem[i] = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) api_mem[i] = '1;
        api_mem[16][19:0]  = 20'hFFFFF;
        api_mem[64][10:0]  = 11'h7FF;
        api_mem[128][15:0] = 16'hFFFF;
        api_mem[160][11:0] = 12'd3500;

        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_flags", {decompress_done, err_illegal_d, err_range, api_rd_en, mem_wr_en}, 0);
        chk("reset_addrs", {api_rd_addr, mem_wr_addr}, 0);
        chk("reset_wr_data", mem_wr_data, 0);
        reset = 1'b0;
        tick();

        // d=1, all ones: every coefficient decompresses to 1665
        start_op(1, 1, 0, 'h100);
        chk("d1_busy_after_start", busy, 1);
        wait_done(200);
        chk("d1_done_cnt", done_cnt, 1);
        chk("d1_latency_le_72", ((done_cyc - c0) <= 72), 1);
        chk("d1_reads", n_rd, 4);
        chk("d1_rd_seq", rd_seq_err, 0);
        chk("d1_writes", n_wr, 64);
        chk("d1_first_data", wr_data_log[0], {4{24'd1665}});
        chk("d1_last_addr", wr_addr_log[63], 15'h13F);
        chk("d1_model", verify(1, 1, 0, 'h100), 0);
        chk("d1_idle_busy", busy, 0);

        start_op(5, 1, 16, 'h200);
        wait_done(200);
        chk("d5_done_cnt", done_cnt, 1);
        chk("d5_reads", n_rd, 20);
        chk("d5_first_data", wr_data_log[0], {4{24'd3225}});
        chk("d5_model", verify(5, 1, 16, 'h200), 0);

        start_op(11, 1, 64, 'h300);
        wait_done(200);
        chk("d11_reads", n_rd, 44);
        chk("d11_first_coef", wr_data_log[0][23:0], 24'd3327);
        chk("d11_model", verify(11, 1, 64, 'h300), 0);

        start_op(4, 1, 128, 'h400);
        wait_done(200);
        chk("d4_first_data", wr_data_log[0], {4{24'd3121}});
        chk("d4_model", verify(4, 1, 128, 'h400), 0);

        // d=12 passthrough, two polynomials, ready toggling every cycle
        ready_mode = 1;
        start_op(12, 2, 160, 'h500);
        wait_done(800);
        ready_mode = 0;
        chk("d12_done_cnt", done_cnt, 1);
        chk("d12_reads", n_rd, 96);
        chk("d12_writes", n_wr, 128);
        chk("d12_hold_stable", hold_err, 0);
        chk("d12_first_coef", wr_data_log[0][23:0], 24'd3500);
        chk("d12_model", verify(12, 2, 160, 'h500), 0);
        chk("d12_err_range", err_range, exp_rng);

        // illegal depth: error pulse only
        start_op(13, 1, 0, 0);
        chk("bad_d_pulse", err_illegal_d, 1);
        chk("bad_d_busy", busy, 0);
        repeat (4) tick();
        chk("bad_d_pulse_cnt", ill_cnt, 1);
        chk("bad_d_traffic", {n_rd[15:0], n_wr[15:0], done_cnt[15:0]}, 0);
        chk("bad_d_err_range_held", err_range, exp_rng);

        // zero polynomials: straight to done
        start_op(3, 0, 0, 0);
        chk("np0_done_next", decompress_done, 1);
        chk("np0_busy", busy, 1);
        repeat (4) tick();
        chk("np0_done_cnt", done_cnt, 1);
        chk("np0_traffic", {n_rd[15:0], n_wr[15:0]}, 0);
        chk("np0_err_range_cleared", err_range, 0);

        // zeroize after 10 writes aborts silently
        start_op(11, 1, 256, 'h600);
        while (n_wr < 10 && (cyc - c0) < 200) tick();
        chk("zero_reached_10", (n_wr >= 10), 1);
        zeroize = 1'b1;
        tick();
        chk("zero_ctrl", {busy, decompress_done, err_illegal_d, err_range, api_rd_en, mem_wr_en,
                          api_rd_addr, mem_wr_addr}, 0);
        chk("zero_data", mem_wr_data, 0);
        zeroize = 1'b0;
        repeat (6) tick();
        chk("zero_no_done", done_cnt, 0);

        start_op(11, 1, 256, 'h600);
        wait_done(200);
        chk("rerun_done_cnt", done_cnt, 1);
        chk("rerun_reads", n_rd, 44);
        chk("rerun_model", verify(11, 1, 256, 'h600), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/decompress_stream.md
Name: decompress_stream

Overview:
- Parametrised successor to the fixed-mode ML-KEM decompression pipeline.
- Streams packed d-bit coefficients from the API read port through an internal bit gearbox, applies Decompress_d for any d in 1..12, and writes COEFF_PER_CLK coefficients per beat to ABR memory.
- Adds two things the fixed-mode pipeline lacks: write backpressure (mem_wr_ready) and arbitrary d.
- Sits between the API/sampler buffer and the ABR polynomial memory and is driven by the high-level controller.

Parameters:
COEFF_PER_CLK, 4, coefficients per write beat; power of two in 1..16.
RD_W, 64, API read data width in bits.
BUF_W, 128, gearbox capacity in bits; must be >= RD_W + COEFF_PER_CLK*12 - 1.
ADDR_W, 15, memory/API address width.
OUT_W, 24, stored coefficient width; zero-padded above bit 11.
N, 256, coefficients per polynomial.
Q, 3329, modulus.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
zeroize  in  1  synchronous clear, same effect as reset
decompress_enable  in  1  start pulse; sampled only when idle
d_sel  in  4  compression depth d; legal values 1..12; held stable while busy
num_poly  in  3  polynomials to process; 0 is legal
src_base_addr  in  ADDR_W  first API word address
dest_base_addr  in  ADDR_W  first memory write address
api_rd_en  out  1  API read strobe
api_rd_addr  out  ADDR_W  API read address
api_rd_data  in  RD_W  read data, valid exactly 1 cycle after api_rd_en; LSB-first bitstream
mem_wr_en  out  1  write request
mem_wr_addr  out  ADDR_W  write address
mem_wr_data  out  COEFF_PER_CLK*OUT_W  coefficient i occupies slice [i*OUT_W +: OUT_W]
mem_wr_ready  in  1  write accepted when mem_wr_en & mem_wr_ready
busy  out  1  operation in progress
decompress_done  out  1  single-cycle completion pulse
err_illegal_d  out  1  single-cycle pulse on a rejected start
err_range  out  1  sticky range flag (optional feature)

Behaviour:
- Reset/zeroize values:
  - All outputs are 0.
  - FSM goes to IDLE; gearbox fill, in-flight flag and counters are cleared.
  - Buffer contents are zeroed, because zeroize must scrub key material.
  - Zeroize mid-operation aborts silently; no done pulse.
- FSM IDLE -> RUN on decompress_enable with d_sel in 1..12 and num_poly != 0:
  - latch d, num_poly, rd_addr = src_base_addr, wr_addr = dest_base_addr;
  - total_rd = num_poly*N*d/RD_W (exact for RD_W = 64);
  - total_wr = num_poly*N/COEFF_PER_CLK.
- IDLE with enable and d_sel = 0 or 13..15: err_illegal_d pulses next cycle; stay IDLE; no memory or API traffic.
- IDLE with enable and num_poly = 0: go to DONE; done pulses next cycle; no traffic.
- Enable while busy is ignored.
- RUN read issue:
  - api_rd_en = 1 iff rd_cnt < total_rd and (BUF_W - fill - RD_W*inflight) >= RD_W.
  - rd_addr increments by 1 per read.
- Returned data is appended above the current fill on the cycle after api_rd_en.
- Pop: when fill >= COEFF_PER_CLK*d and the output register is empty or being accepted this cycle:
  - extract the low COEFF_PER_CLK*d bits and shift the buffer down;
  - a push and a pop in the same cycle are both applied: fill += RD_W - COEFF_PER_CLK*d.
- Decompress per coefficient x (d bits, zero-extended):
  - d < 12: y = (x*Q + 2^(d-1)) >> d; 24-bit intermediate; y <= 3328.
  - d = 12: y = x (passthrough).
- Output register: mem_wr_en/addr/data load on pop. While mem_wr_en & !mem_wr_ready, data and address hold stable and pops stall.
- On each accepted write: wr_addr += 1, wr_cnt += 1.
- RUN -> DONE when the final write is accepted (wr_cnt reaches total_wr). DONE lasts one cycle: decompress_done = 1, busy = 0 next cycle, back to IDLE.
- busy = 1 from the cycle after an accepted start through the DONE cycle.
- The gearbox is empty at completion; no leftover bits by construction.
- Throughput: with mem_wr_ready tied high, one write per cycle in steady state.

Optional Feature:
- Macro: DECOMPRESS_STREAM_RANGE_CHK_EN.
- Defined:
  - with d = 12, any popped coefficient >= Q sets err_range;
  - err_range is sticky until the next accepted start, reset or zeroize;
  - the data is still written unchanged.
- Undefined: err_range is tied to 0 and no comparator logic is present.

Test Plan:
- d=1, num_poly=1, all API bits 1, ready=1 -> 4 reads (addr src..src+3); 64 writes of four 1665 coefficients (addr dest..dest+63); one done pulse; done within 72 cycles of enable.
- d=5, word 0 low 20 bits = 0xFFFFF, ready=1 -> first write data = four copies of 3225; d=11, x=2047 -> 3327; d=4, x=15 -> 3121.
- d=12, num_poly=2, ready toggling 1/0 every cycle -> 128 writes; mem_wr_data/addr stable while ready=0; no data lost or duplicated; 96 reads total.
- d_sel=13 with enable -> err_illegal_d pulse, no api_rd_en/mem_wr_en, busy stays 0; num_poly=0 -> done pulse 1 cycle after enable, no traffic.
- zeroize asserted mid-RUN (d=11, after 10 writes) -> next cycle all outputs 0 and no done; a new enable then completes a full correct run.
- With DECOMPRESS_STREAM_RANGE_CHK_EN, d=12, one coefficient = 3500 -> err_range set and held; written value 3500; cleared by the next start. Without the macro -> err_range stays 0.
